// File: rtl/bls_sub_seq.sv
// Multi-cycle WIDTH-bit subtractor, one borrow-lookahead nibble per clock.
// Optional signed overflow output enabled by defining BLS_SUB_OVF_EN.
module bls_sub_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef BLS_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, busy_q, done_q, bout_q, zero_q;
`ifdef BLS_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic [3:0]       g, p, bn, diff;
    logic             b4;
    logic [WIDTH-1:0] d_d;

    // Operands shift right so the active nibble is always at [3:0].
    always_comb begin
        g     = ~a_q[3:0] & b_q[3:0];
        p     = ~a_q[3:0] | b_q[3:0];
        bn[0] = br_q;
        bn[1] = g[0] | (p[0] & br_q);
        bn[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_q);
        bn[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & br_q);
        b4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & br_q);
        diff  = a_q[3:0] ^ b_q[3:0] ^ bn;
        d_d   = d_q;
        d_d[{cnt_q, 2'b00} +: 4] = diff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef BLS_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    br_q  <= b4;
                    d_q   <= d_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= b4;
                        zero_q  <= (d_d == '0);
`ifdef BLS_SUB_OVF_EN
                        // a_q[3]/b_q[3] hold the original sign bits here
                        ovf_q   <= (a_q[3] ^ b_q[3]) & (a_q[3] ^ diff[3]);
`endif
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef BLS_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
